// File: rtl/cache_refill_ctrl_if.sv
// Bundle of the L1 miss handshake, memory beat bus and refill outputs of the refill controller.
interface cache_refill_ctrl_if #(
  parameter int unsigned LINE_WORDS = 4
) ();
  logic                       miss_req;
  logic                       miss_ready;
  logic [31:0]                miss_addr;
  logic                       evict_dirty;
  logic [31:0]                evict_addr;
  logic [32*LINE_WORDS-1:0]   evict_data;

  logic                       mem_req;
  logic                       mem_we;
  logic [31:0]                mem_addr;
  logic [31:0]                mem_wdata;
  logic                       mem_gnt;
  logic                       mem_rvalid;
  logic [31:0]                mem_rdata;

  logic                       fill_valid;
  logic [31:0]                fill_addr;
  logic [32*LINE_WORDS-1:0]   fill_data;
  logic                       err;

  // Controller side.
  modport master (
    input  miss_req, miss_addr, evict_dirty, evict_addr, evict_data,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output miss_ready, mem_req, mem_we, mem_addr, mem_wdata,
    output fill_valid, fill_addr, fill_data, err
  );

  // L1 / memory side.
  modport slave (
    output miss_req, miss_addr, evict_dirty, evict_addr, evict_data,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  miss_ready, mem_req, mem_we, mem_addr, mem_wdata,
    input  fill_valid, fill_addr, fill_data, err
  );
endinterface

// File: rtl/cache_refill_ctrl.sv
// Cache line refill controller: optional dirty write-back, then a beat-by-beat line read
// with one outstanding read, a per-beat timeout and a single-cycle fill pulse.
module cache_refill_ctrl #(
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned TIMEOUT    = 255
) (
  input logic                 clk,
  input logic                 rst_n,
  cache_refill_ctrl_if.master bus_io
);

  localparam int unsigned BeatW = $clog2(LINE_WORDS);
  localparam int unsigned OffW  = BeatW + 2;
  localparam int unsigned WaitW = $clog2(TIMEOUT + 1);
  localparam int unsigned LineW = 32 * LINE_WORDS;

  localparam logic [31:0]      OffMask  = (32'd1 << OffW) - 32'd1;
  localparam logic [BeatW-1:0] LastBeat = BeatW'(LINE_WORDS - 1);
  localparam logic [WaitW-1:0] WaitLast = WaitW'(TIMEOUT - 1);

  typedef enum logic [2:0] {StIdle, StWbReq, StRdReq, StRdWait, StFill} state_e;

  state_e             state_q, state_d;
  logic [BeatW-1:0]   beat_q, beat_d;
  logic [WaitW-1:0]   wait_q, wait_d;
  logic [31:0]        miss_base_q, miss_base_d;
  logic [31:0]        evict_base_q, evict_base_d;
  logic [LineW-1:0]   line_q, line_d;
  logic [31:0]        fill_addr_q, fill_addr_d;
  logic [LineW-1:0]   fill_data_q, fill_data_d;
  logic               err_q, err_d;

  logic               last_beat;
  logic               progress;
  logic               active;
  logic [31:0]        beat_off;
  logic [31:0]        wb_word;

  assign last_beat = (beat_q == LastBeat);
  assign beat_off  = {{(30 - BeatW){1'b0}}, beat_q, 2'b00};
  assign wb_word   = line_q[{beat_q, 5'b0} +: 32];
  assign active    = (state_q == StWbReq) || (state_q == StRdReq) || (state_q == StRdWait);

  assign bus_io.fill_addr = fill_addr_q;
  assign bus_io.fill_data = fill_data_q;
  assign bus_io.err       = err_q;

  // Next-state, beat/wait counters and bus outputs.
  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    wait_d       = wait_q;
    miss_base_d  = miss_base_q;
    evict_base_d = evict_base_q;
    line_d       = line_q;
    fill_addr_d  = fill_addr_q;
    fill_data_d  = fill_data_q;
    err_d        = 1'b0;
    progress     = 1'b0;

    bus_io.miss_ready = 1'b0;
    bus_io.mem_req    = 1'b0;
    bus_io.mem_we     = 1'b0;
    bus_io.mem_addr   = '0;
    bus_io.mem_wdata  = '0;
    bus_io.fill_valid = 1'b0;

    unique case (state_q)
      StIdle: begin
        bus_io.miss_ready = 1'b1;
        if (bus_io.miss_req) begin
          miss_base_d  = bus_io.miss_addr & ~OffMask;
          evict_base_d = bus_io.evict_addr & ~OffMask;
          line_d       = bus_io.evict_data;
          beat_d       = '0;
          state_d      = bus_io.evict_dirty ? StWbReq : StRdReq;
        end
      end
      StWbReq: begin
        bus_io.mem_req   = 1'b1;
        bus_io.mem_we    = 1'b1;
        bus_io.mem_addr  = evict_base_q | beat_off;
        bus_io.mem_wdata = wb_word;
        if (bus_io.mem_gnt) begin
          progress = 1'b1;
          if (last_beat) begin
            beat_d  = '0;
            state_d = StRdReq;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      StRdReq: begin
        bus_io.mem_req  = 1'b1;
        bus_io.mem_addr = miss_base_q | beat_off;
        if (bus_io.mem_gnt) begin
          progress = 1'b1;
          state_d  = StRdWait;
        end
      end
      StRdWait: begin
        // Only here is read data consumed; rvalid alongside the grant is never seen.
        if (bus_io.mem_rvalid) begin
          progress = 1'b1;
          line_d[{beat_q, 5'b0} +: 32] = bus_io.mem_rdata;
          if (last_beat) begin
            fill_addr_d = miss_base_q;
            fill_data_d = line_d;
            beat_d      = '0;
            state_d     = StFill;
          end else begin
            beat_d  = beat_q + 1'b1;
            state_d = StRdReq;
          end
        end
      end
      StFill: begin
        bus_io.fill_valid = 1'b1;
        state_d           = StIdle;
      end
      default: begin
        state_d = StIdle;
        beat_d  = '0;
      end
    endcase

    // Any handshake (and hence any state change) restarts the per-beat wait budget.
    if (!active || progress) begin
      wait_d = '0;
    end else if (wait_q == WaitLast) begin
      state_d = StIdle;
      beat_d  = '0;
      wait_d  = '0;
      err_d   = 1'b1;
    end else begin
      wait_d = wait_q + 1'b1;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      beat_q       <= '0;
      wait_q       <= '0;
      miss_base_q  <= '0;
      evict_base_q <= '0;
      line_q       <= '0;
      fill_addr_q  <= '0;
      fill_data_q  <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      wait_q       <= wait_d;
      miss_base_q  <= miss_base_d;
      evict_base_q <= evict_base_d;
      line_q       <= line_d;
      fill_addr_q  <= fill_addr_d;
      fill_data_q  <= fill_data_d;
      err_q        <= err_d;
    end
  end

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Scoreboard bench for cache_refill_ctrl: a memory responder with programmable grant/read
// delays, expected beats and fills queued at stimulus time and compared as they appear.
module tb_cache_refill_ctrl;

  localparam int unsigned LW  = 4;
  localparam int unsigned TMO = 255;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } beat_t;

  typedef struct {
    logic [31:0]  addr;
    logic [127:0] data;
    int           lat;
  } fill_t;

  logic clk;
  logic rst_n;

  cache_refill_ctrl_if #(.LINE_WORDS(LW)) bus ();

  cache_refill_ctrl #(
    .LINE_WORDS (LW),
    .TIMEOUT    (TMO)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  beat_t beat_q[$];
  fill_t fill_q[$];

  // Responder knobs.
  int          gnt_delay  = 0;
  int          rv_delay   = 0;
  bit          rd_en      = 1'b1;
  bit          spur       = 1'b0;
  bit          chk_stable = 1'b0;
  logic [31:0] rd_seed    = 32'h0;

  int acc_cyc    = 0;
  int err_cyc    = 0;
  int err_seen   = 0;
  int fills_seen = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    return rd_seed + ((a >> 2) & 32'(LW - 1));
  endfunction

  // Memory responder and output monitor, all at the falling edge.
  initial begin
    logic        req_was, we_was, gnt_was, fv_was;
    logic [31:0] addr_was, wdata_was, rd_addr;
    bit          rd_pending;
    int          rd_wait, gw;
    beat_t       b;
    fill_t       f;
    req_was = 0; we_was = 0; gnt_was = 0; fv_was = 0;
    addr_was = '0; wdata_was = '0; rd_addr = '0;
    rd_pending = 0; rd_wait = 0; gw = 0;
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      // Beat accepted at the previous rising edge.
      if (req_was && gnt_was) begin
        if (beat_q.size() == 0) begin
          check("beat_extra", 256'(addr_was), 256'(0));
        end else begin
          b = beat_q.pop_front();
          check("beat_we", 256'(we_was), 256'(b.we));
          check("beat_addr", 256'(addr_was), 256'(b.addr));
          if (b.we) check("beat_wdata", 256'(wdata_was), 256'(b.wdata));
        end
        if (!we_was) begin
          rd_pending = 1; rd_addr = addr_was; rd_wait = 0;
        end
      end else if (chk_stable && rst_n && req_was) begin
        check("hold_req", 256'(bus.mem_req), 256'(1'b1));
        check("hold_addr", 256'(bus.mem_addr), 256'(addr_was));
        check("hold_wdata", 256'(bus.mem_wdata), 256'(wdata_was));
      end
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = '0;
      if (!rd_en || !rst_n) rd_pending = 0;
      if (rd_pending) begin
        if (rd_wait >= rv_delay) begin
          bus.mem_rvalid = 1'b1;
          bus.mem_rdata  = rd_word(rd_addr);
          rd_pending     = 0;
        end else begin
          rd_wait++;
        end
      end
      bus.mem_gnt = 1'b0;
      if (bus.mem_req) begin
        if (gw >= gnt_delay) begin
          bus.mem_gnt = 1'b1;
          gw = 0;
        end else begin
          gw++;
        end
      end else begin
        gw = 0;
      end
      if (spur && bus.mem_gnt && !bus.mem_rvalid) begin
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'hDEAD_BEEF;
      end
      if (bus.fill_valid) begin
        fills_seen++;
        check("fill_pulse", 256'(fv_was), 256'(1'b0));
        if (fill_q.size() == 0) begin
          check("fill_extra", 256'(bus.fill_addr), 256'(0));
        end else begin
          f = fill_q.pop_front();
          check("fill_addr", 256'(bus.fill_addr), 256'(f.addr));
          check("fill_data", 256'(bus.fill_data), 256'(f.data));
          if (f.lat >= 0) check("fill_lat", 256'(cyc - acc_cyc), 256'(f.lat));
        end
      end
      if (bus.err) begin
        err_seen++;
        err_cyc = cyc;
        check("err_ready", 256'(bus.miss_ready), 256'(1'b1));
        check("err_nofill", 256'(bus.fill_valid), 256'(1'b0));
      end
      req_was   = bus.mem_req;
      we_was    = bus.mem_we;
      gnt_was   = bus.mem_gnt;
      addr_was  = bus.mem_addr;
      wdata_was = bus.mem_wdata;
      fv_was    = bus.fill_valid;
    end
  end

  // Present one miss and queue the beats and fill it should produce.
  task automatic issue(input logic [31:0] maddr, input logic dirty, input logic [31:0] eaddr,
                       input logic [127:0] edata, input int n_wr, input int n_rd,
                       input bit exp_fill, input int lat);
    logic [31:0]  mb, eb;
    logic [127:0] fd;
    beat_t        b;
    fill_t        f;
    mb = maddr & ~32'hF;
    eb = eaddr & ~32'hF;
    fd = '0;
    for (int i = 0; i < n_wr; i++) begin
      b.we = 1'b1; b.addr = eb + 32'(4 * i); b.wdata = edata[32*i +: 32];
      beat_q.push_back(b);
    end
    for (int i = 0; i < n_rd; i++) begin
      b.we = 1'b0; b.addr = mb + 32'(4 * i); b.wdata = '0;
      beat_q.push_back(b);
    end
    for (int i = 0; i < int'(LW); i++) fd[32*i +: 32] = rd_word(mb + 32'(4 * i));
    if (exp_fill) begin
      f.addr = mb; f.data = fd; f.lat = lat;
      fill_q.push_back(f);
    end
    @(negedge clk);
    bus.miss_req    = 1'b1;
    bus.miss_addr   = maddr;
    bus.evict_dirty = dirty;
    bus.evict_addr  = eaddr;
    bus.evict_data  = edata;
    check("miss_ready", 256'(bus.miss_ready), 256'(1'b1));
    acc_cyc = cyc;
    @(negedge clk);
    bus.miss_req = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while ((beat_q.size() != 0 || fill_q.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 256'(beat_q.size() == 0 && fill_q.size() == 0), 256'(1'b1));
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int fs0, es0, n;
    bus.miss_req = 1'b0; bus.miss_addr = '0; bus.evict_dirty = 1'b0;
    bus.evict_addr = '0; bus.evict_data = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #3;
    check("rst_mem_req", 256'(bus.mem_req), 256'(0));
    check("rst_mem_we", 256'(bus.mem_we), 256'(0));
    check("rst_fill_valid", 256'(bus.fill_valid), 256'(0));
    check("rst_err", 256'(bus.err), 256'(0));
    check("rst_mem_addr", 256'(bus.mem_addr), 256'(0));
    check("rst_mem_wdata", 256'(bus.mem_wdata), 256'(0));
    check("rst_fill_addr", 256'(bus.fill_addr), 256'(0));
    check("rst_fill_data", 256'(bus.fill_data), 256'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 256'(bus.miss_ready), 256'(1));

    // Clean miss, zero-wait memory.
    rd_seed = 32'hA0;
    issue(32'h0000_1004, 1'b0, 32'h0, 128'h0, 0, 4, 1'b1, 9);
    wait_done("clean_done", 100);
    repeat (3) @(negedge clk);
    check("fill_hold_data", 256'(bus.fill_data), 256'({32'hA3, 32'hA2, 32'hA1, 32'hA0}));
    check("fill_hold_addr", 256'(bus.fill_addr), 256'(32'h1000));

    // Dirty miss: write-back strictly before reads.
    rd_seed = 32'h30;
    issue(32'h0000_3000, 1'b1, 32'h0000_2000, {32'hD3, 32'hD2, 32'hD1, 32'hD0}, 4, 4, 1'b1, 13);
    wait_done("dirty_done", 100);

    // Backpressure on every beat plus slow read data.
    gnt_delay = 3; rv_delay = 1; chk_stable = 1'b1;
    rd_seed = 32'h5500;
    issue(32'h0000_500C, 1'b1, 32'h0000_4010, {32'h44, 32'h33, 32'h22, 32'h11}, 4, 4, 1'b1, -1);
    wait_done("bp_done", 300);
    gnt_delay = 0; rv_delay = 0; chk_stable = 1'b0;

    // Stray rvalid alongside each grant must be ignored.
    spur = 1'b1;
    rd_seed = 32'h6600;
    issue(32'h0000_6008, 1'b0, 32'h0, 128'h0, 0, 4, 1'b1, 9);
    wait_done("spur_done", 100);
    spur = 1'b0;

    // New miss request during RD_WAIT is dropped.
    rd_seed = 32'h7700;
    fs0 = fills_seen;
    issue(32'h0000_7000, 1'b0, 32'h0, 128'h0, 0, 4, 1'b1, 9);
    n = 0;
    while (!(!bus.mem_req && !bus.miss_ready) && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("find_rd_wait", 256'(n < 20), 256'(1'b1));
    bus.miss_req = 1'b1; bus.miss_addr = 32'h0000_8000;
    @(negedge clk);
    bus.miss_req = 1'b0;
    wait_done("ignore_done", 100);
    repeat (5) @(negedge clk);
    check("one_fill", 256'(fills_seen - fs0), 256'(1));

    // Read data never arrives: timeout abort.
    rd_en = 1'b0;
    rd_seed = 32'h9900;
    es0 = err_seen;
    fs0 = fills_seen;
    issue(32'h0000_9000, 1'b0, 32'h0, 128'h0, 0, 1, 1'b0, -1);
    n = 0;
    while (err_seen == es0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    check("tmo_err_count", 256'(err_seen - es0), 256'(1));
    check("tmo_err_lat", 256'(err_cyc - acc_cyc), 256'(TMO + 2));
    check("tmo_no_fill", 256'(fills_seen - fs0), 256'(0));
    check("tmo_beats", 256'(beat_q.size()), 256'(0));
    check("tmo_idle", 256'(bus.miss_ready), 256'(1));
    rd_en = 1'b1;

    // Reset while write-back beat 2 is stalled.
    gnt_delay = 2;
    rd_seed = 32'hBB00;
    es0 = err_seen;
    fs0 = fills_seen;
    issue(32'h0000_B000, 1'b1, 32'h0000_A000, {32'hE3, 32'hE2, 32'hE1, 32'hE0}, 2, 0, 1'b0, -1);
    n = 0;
    while (!(bus.mem_req && bus.mem_addr == 32'h0000_A008) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("find_wb2", 256'(n < 50), 256'(1'b1));
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_req", 256'(bus.mem_req), 256'(0));
    check("rst_mid_fill", 256'(bus.fill_valid), 256'(0));
    check("rst_mid_err", 256'(bus.err), 256'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    gnt_delay = 0;
    @(negedge clk);
    check("rst_mid_ready", 256'(bus.miss_ready), 256'(1));
    check("rst_mid_beats", 256'(beat_q.size()), 256'(0));
    check("rst_mid_no_err", 256'(err_seen - es0), 256'(0));
    check("rst_mid_no_fill", 256'(fills_seen - fs0), 256'(0));

    rd_seed = 32'hCC00;
    issue(32'h0000_C004, 1'b0, 32'h0, 128'h0, 0, 4, 1'b1, 9);
    wait_done("post_rst_done", 100);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
